rr_mux_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4-to-1 bit-select path between four requesters.
- Grants at most one requester at a time and drives the 2-bit mux select {sel_a, sel_b}.
- Forwards the granted requester's data bit to a registered output.
- Sits in front of the lab's 4:1 select datapath and replaces static switch-driven selection with request/grant sequencing.

---
 rtl/rr_arb_defs.sv | 19 +
 rtl/rr_priority_pick.sv | 47 ++++
 rtl/rr_mux_arbiter.sv | 125 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_defs.sv
// rr_arb_defs: shared definitions for the round-robin mux arbiter.
//   - FSM state encoding (ST_IDLE / ST_GRANT)
//   - requester count and index width
//   - idx_to_onehot: index -> one-hot grant vector
package rr_arb_defs;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational rotating priority picker.
// Ports:
//   req      in  [N_REQ-1:0]  request vector
//   start    in  [IDX_W-1:0]  index that gets highest priority
//   excl_en  in  1            when high, excl_idx is removed from the search
//   excl_idx in  [IDX_W-1:0]  index to exclude
//   found    out 1            some eligible request exists
//   winner   out [IDX_W-1:0]  first eligible index at or after start (wrapping)
module rr_priority_pick
  import rr_arb_defs::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  input  logic             excl_en,
  input  logic [IDX_W-1:0] excl_idx,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  logic [N_REQ-1:0]   masked;
  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [IDX_W-1:0]   offset;

  always_comb begin
    masked = req;
    if (excl_en) masked[excl_idx] = 1'b0;

    // Rotate so that bit 0 of 'rotated' is requester 'start'.
    doubled = {masked, masked} >> start;
    rotated = doubled[N_REQ-1:0];

    // Fixed-priority encode, lowest rotated bit wins.
    found  = 1'b0;
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = IDX_W'(i);
      end
    end

    // Un-rotate: index arithmetic wraps naturally in IDX_W bits.
    winner = start + offset;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter sharing one 4:1 bit-select path.
// Ports:
//   clk       in  1  rising-edge clock
//   reset     in  1  asynchronous active-high reset
//   req       in  4  request lines, req[i] = requester i wants the path
//   data_in   in  4  data bits, data_in[i] belongs to requester i
//   grant     out 4  registered one-hot grant, zero when idle
//   sel_a     out 1  registered select MSB
//   sel_b     out 1  registered select LSB ({sel_a,sel_b} = current/last owner)
//   busy      out 1  |grant
//   y         out 1  registered forwarded data bit
//   dbg_state out 1  current FSM state (0 = IDLE, 1 = GRANT)
// Handshake: req[i] is a level request; grant[i] is the acknowledge and stays
// high for as long as requester i owns the path. A requester may drop req at
// any time; ownership ends at the next edge.
module rr_mux_arbiter
  import rr_arb_defs::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_in,
  output logic [N_REQ-1:0] grant,
  output logic             sel_a,
  output logic             sel_b,
  output logic             busy,
  output logic             y,
  output logic             dbg_state
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             y_q, y_d;

  logic             busy_q;
  logic             found;
  logic [IDX_W-1:0] winner;

  assign busy_q = |grant_q;

  // Search begins just after the last owner. While granting, the owner is
  // excluded so a forced rotation never re-selects it.
  rr_priority_pick u_pick (
    .req      (req),
    .start    (last_q + IDX_W'(1)),
    .excl_en  (state_q == ST_GRANT),
    .excl_idx (last_q),
    .found    (found),
    .winner   (winner)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    y_d     = busy_q ? data_in[sel_q] : 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_GRANT;
          last_d  = winner;
          sel_d   = winner;
          hold_d  = '0;
          grant_d = idx_to_onehot(winner);
        end
      end
      ST_GRANT: begin
        if (req[last_q] && (hold_q < HOLD_LAST)) begin
          hold_d = hold_q + CNT_W'(1);
        end else if (found) begin
          // Owner released, or hold limit reached with someone waiting.
          last_d  = winner;
          sel_d   = winner;
          hold_d  = '0;
          grant_d = idx_to_onehot(winner);
        end else if (!req[last_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
        // Otherwise: owner at the limit with nobody waiting; counter saturates.
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= IDX_W'(N_REQ - 1);
      sel_q   <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      y_q     <= y_d;
    end
  end

  assign grant     = grant_q;
  assign sel_a     = sel_q[1];
  assign sel_b     = sel_q[0];
  assign busy      = busy_q;
  assign y         = y_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed and random checks of rr_mux_arbiter.
// Expected word layout: {grant[3:0], sel[1:0], busy, y}.
module tb_rr_mux_arbiter;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] data_in = '0;
  logic [3:0] grant;
  logic       sel_a, sel_b, busy, y, dbg_state;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .busy      (busy),
    .y         (y),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got grant=%b sel=%b busy=%b y=%b, want grant=%b sel=%b busy=%b y=%b",
               name, got[7:4], got[3:2], got[1], got[0], want[7:4], want[3:2], want[1], want[0]);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      n_cmp++;
      assert ($onehot0(grant)) else begin
        n_bad++;
        $display("FAIL onehot: got grant=%b, want one-hot or zero", grant);
      end
      if (exp_q.size() != 0) begin
        logic [W-1:0] e;
        string        t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {grant, sel_a, sel_b, busy, y}, e);
      end
    end
  end

  // ---------------- reference model (random phase) ----------------
  logic       m_state;
  logic [1:0] m_last, m_sel;
  int         m_hold;
  logic [3:0] m_grant;

  task automatic model_reset();
    m_state = 1'b0;
    m_last  = 2'd3;
    m_sel   = 2'd0;
    m_hold  = 0;
    m_grant = 4'b0000;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                      input logic [1:0] s, input logic yv, input string tag);
    @(negedge clk);
    req     = r;
    data_in = d;
    exp_q.push_back({g, s, |g, yv});
    tag_q.push_back(tag);
  endtask

  task automatic rand_step(input logic [3:0] r, input logic [3:0] d);
    logic       found;
    logic [1:0] w, idx;
    logic       ny;
    found = 1'b0;
    w     = 2'd0;
    for (int off = 1; off <= 4; off++) begin
      idx = m_last + 2'(off);
      if (!found && r[idx] && !(m_state && idx == m_last)) begin
        found = 1'b1;
        w     = idx;
      end
    end
    ny = (m_grant != 4'b0000) ? d[m_sel] : 1'b0;
    if (!m_state) begin
      if (found) begin
        m_state = 1'b1; m_last = w; m_sel = w; m_hold = 0; m_grant = 4'b0001 << w;
      end
    end else if (r[m_last] && m_hold < 7) begin
      m_hold++;
    end else if (found) begin
      m_last = w; m_sel = w; m_hold = 0; m_grant = 4'b0001 << w;
    end else if (!r[m_last]) begin
      m_state = 1'b0; m_grant = 4'b0000;
    end
    step(r, d, m_grant, m_sel, ny, "random");
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    req     = '0;
    data_in = '0;
    reset   = 1'b1;
    #1;
    check({tag, "_reset"}, {grant, sel_a, sel_b, busy, y}, 8'b0000_00_0_0);
    n_cmp++;
    if (dbg_state !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_state: got %b, want 0", tag, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] dpat;
    logic [3:0] r;
    int         o, p;

    do_reset("init");

    // Single requester 0: grant after 1 cycle, data after 1 more, then release.
    step(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b0, "single_0");
    step(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, "single_1");
    step(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, "single_2");
    step(4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, "single_drop");
    step(4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, "single_idle");
    drain();

    // All requesting: each owner holds exactly 8 cycles, order 0,1,2,3,0.
    do_reset("rot");
    dpat = 4'b0101;
    for (int k = 0; k < 45; k++) begin
      o = (k / 8) % 4;
      p = ((k - 1) / 8) % 4;
      step(4'b1111, dpat, 4'b0001 << o, 2'(o), (k == 0) ? 1'b0 : dpat[p], "rotate");
    end
    drain();

    // Lone owner 2 keeps the path past the hold limit, then yields to req[0].
    do_reset("hold");
    for (int k = 0; k < 20; k++)
      step(4'b0100, 4'b0100, 4'b0100, 2'd2, (k == 0) ? 1'b0 : 1'b1, "hold_lone");
    step(4'b0101, 4'b0100, 4'b0001, 2'd0, 1'b1, "hold_yield");
    step(4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0, "hold_release");
    drain();

    // Owner 1 drops while 0 and 3 wait: 3 comes first in rotation, no bubble.
    do_reset("drop");
    step(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b0, "drop_own1");
    step(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, "drop_own1b");
    step(4'b1001, 4'b0010, 4'b1000, 2'd3, 1'b1, "drop_switch");
    step(4'b1001, 4'b0010, 4'b1000, 2'd3, 1'b0, "drop_own3");
    step(4'b0000, 4'b0010, 4'b0000, 2'd3, 1'b0, "drop_idle");
    drain();

    // Asynchronous reset in the middle of a grant.
    do_reset("async");
    step(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, "async_g0");
    step(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, "async_g1");
    step(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, "async_g2");
    drain();
    @(posedge clk);
    #3;
    reset = 1'b1;
    req   = 4'b0000;
    #1;
    check("async_mid_reset", {grant, sel_a, sel_b, busy, y}, 8'b0000_00_0_0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(4'b0110, 4'b0100, 4'b0010, 2'd1, 1'b0, "async_restart");
    step(4'b0000, 4'b0100, 4'b0000, 2'd1, 1'b0, "async_release");
    drain();

    // Random traffic checked against the reference model.
    do_reset("rand");
    r = 4'b0000;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      rand_step(r, 4'($urandom_range(0, 15)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
